mem_responder: RTL and testbench

MEM_RESPONDER -- requirements
Module: mem_responder

---
 rtl/mem_responder.sv | 180 ++++++++++++++++++
 tb/tb_mem_responder.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/mem_responder.sv
`default_nettype none
// ============================================================================
// Module      : mem_responder
// Description : Single-port word memory behind a Rd/Wr/Done handshake. A read
//               of the most recently completed word index completes in one
//               cycle (CacheHit); every other access takes LATENCY cycles.
//               Malformed requests raise a sticky err flag.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_responder #(
    parameter int N       = 16,
    parameter int AW      = 8,
    parameter int LATENCY = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         Rd,
    input  logic         Wr,
    input  logic [N-1:0] Addr,
    input  logic [N-1:0] DataIn,
    input  logic         createdump,
    output logic [N-1:0] DataOut,
    output logic         Done,
    output logic         Stall,
    output logic         CacheHit,
    output logic         err
);

    localparam int         c_depth    = 1 << AW;
    localparam logic [3:0] c_lat_load = 4'(LATENCY - 1);
    localparam bit         c_direct   = (LATENCY == 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t         r_state;
    state_t         w_state_nxt;
    logic [3:0]     r_cnt;
    logic [3:0]     w_cnt_nxt;

    // Captured request
    logic           r_op_wr;
    logic [AW-1:0]  r_idx;
    logic [N-1:0]   r_wdata;
    logic           r_hit;

    // Completion bookkeeping
    logic [AW-1:0]  r_last_idx;
    logic           r_last_vld;
    logic           r_err;
    logic [N-1:0]   r_dout;

    // Storage array (never reset)
    logic [N-1:0]   r_mem [0:c_depth-1];

    logic [AW-1:0]  w_req_idx;
    logic           w_req_valid;
    logic           w_req_bad;
    logic           w_req_hit;
    logic           w_enter_done;
    logic           w_cur_wr;
    logic [AW-1:0]  w_cur_idx;
    logic [N-1:0]   w_cur_wdata;
    logic           w_unused_ok;

    assign w_req_idx   = Addr[AW:1];
    assign w_req_valid = (r_state == IDLE) && !r_err && (Rd ^ Wr) && !Addr[0];
    assign w_req_bad   = (r_state == IDLE) && !r_err && (Rd | Wr) && ((Rd & Wr) || Addr[0]);
    assign w_req_hit   = Rd && !Wr && r_last_vld && (w_req_idx == r_last_idx);

    // A request can enter DONE on its own sampling edge (hit or LATENCY=1),
    // before the capture registers are loaded, so take the live inputs then.
    assign w_cur_wr    = (r_state == IDLE) ? Wr        : r_op_wr;
    assign w_cur_idx   = (r_state == IDLE) ? w_req_idx : r_idx;
    assign w_cur_wdata = (r_state == IDLE) ? DataIn    : r_wdata;

    assign w_enter_done = (w_state_nxt == DONE) && (r_state != DONE) && !rst;

    // Halt indication and upper address bits carry no function here.
    assign w_unused_ok = ^{createdump, Addr};

    // State and latency counter register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // Next-state and counter logic; BUSY leaves as the counter reaches zero
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        unique case (r_state)
            IDLE: begin
                if (w_req_valid) begin
                    if (w_req_hit || c_direct) begin
                        w_state_nxt = DONE;
                        w_cnt_nxt   = '0;
                    end else begin
                        w_state_nxt = BUSY;
                        w_cnt_nxt   = c_lat_load;
                    end
                end
            end
            BUSY: begin
                if (r_cnt <= 4'd1) begin
                    w_state_nxt = DONE;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt = r_cnt - 4'd1;
                end
            end
            DONE: begin
                w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    // Capture the request so later input changes cannot disturb it
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_op_wr <= 1'b0;
            r_idx   <= '0;
            r_wdata <= '0;
            r_hit   <= 1'b0;
        end else if (w_req_valid) begin
            r_op_wr <= Wr;
            r_idx   <= w_req_idx;
            r_wdata <= DataIn;
            r_hit   <= w_req_hit;
        end
    end

    // Completion: track last index, load read data, latch protocol errors
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_last_idx <= '0;
            r_last_vld <= 1'b0;
            r_dout     <= '0;
            r_err      <= 1'b0;
        end else begin
            if (w_req_bad) begin
                r_err <= 1'b1;
            end
            if (w_enter_done) begin
                r_last_idx <= w_cur_idx;
                r_last_vld <= 1'b1;
                if (!w_cur_wr) begin
                    r_dout <= r_mem[w_cur_idx];
                end
            end
        end
    end

    // Array write on entry to DONE; the array is the single source for hits
    always_ff @(posedge clk) begin
        if (w_enter_done && w_cur_wr) begin
            r_mem[w_cur_idx] <= w_cur_wdata;
        end
    end

    assign Done     = (r_state == DONE);
    assign Stall    = (r_state != IDLE);
    assign CacheHit = (r_state == DONE) && r_hit;
    assign err      = r_err;
    assign DataOut  = r_dout;

endmodule
`default_nettype wire

// File: tb/tb_mem_responder.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_responder
// Description : Self-checking bench for mem_responder. Drives a LATENCY=4 and
//               a LATENCY=1 instance and compares against a behavioural model
//               (word array, last index, held read data).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_responder;

    localparam int N   = 16;
    localparam int AW  = 8;
    localparam int LAT = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        cd;
    logic        rd0, wr0, rd1, wr1;
    logic [15:0] addr0, din0, addr1, din1;
    logic [15:0] dout0, dout1;
    logic        done0, done1, stall0, stall1, hit0, hit1, err0, err1;

    logic        sel = 1'b0;
    logic        o_done, o_stall, o_hit;
    logic [15:0] o_dout;

    int n_pass  = 0;
    int n_fail  = 0;
    int n_total = 0;
    int w;

    // Behavioural model, one per instance
    logic [15:0] m_mem  [2][256];
    logic [7:0]  m_last [2];
    bit          m_vld  [2];
    logic [15:0] m_dout [2];

    mem_responder #(.N(N), .AW(AW), .LATENCY(LAT)) dut (
        .clk(clk), .rst(rst), .Rd(rd0), .Wr(wr0), .Addr(addr0), .DataIn(din0),
        .createdump(cd), .DataOut(dout0), .Done(done0), .Stall(stall0),
        .CacheHit(hit0), .err(err0)
    );

    mem_responder #(.N(N), .AW(AW), .LATENCY(1)) dut1 (
        .clk(clk), .rst(rst), .Rd(rd1), .Wr(wr1), .Addr(addr1), .DataIn(din1),
        .createdump(cd), .DataOut(dout1), .Done(done1), .Stall(stall1),
        .CacheHit(hit1), .err(err1)
    );

    assign o_done  = sel ? done1  : done0;
    assign o_stall = sel ? stall1 : stall0;
    assign o_hit   = sel ? hit1   : hit0;
    assign o_dout  = sel ? dout1  : dout0;

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input int s, input bit rd, input bit wr,
                         input logic [15:0] a, input logic [15:0] d);
        if (s == 0) begin
            rd0 = rd; wr0 = wr; addr0 = a; din0 = d;
        end else begin
            rd1 = rd; wr1 = wr; addr1 = a; din1 = d;
        end
    endtask

    task automatic model_reset();
        for (int s = 0; s < 2; s++) begin
            m_vld[s]  = 1'b0;
            m_dout[s] = 16'h0000;
        end
    endtask

    // One complete access; expectations come from the model before issue
    task automatic access(input int s, input bit rd, input logic [15:0] a, input logic [15:0] d);
        int          cyc;
        int          stall_cyc;
        logic [7:0]  idx;
        bit          exp_hit;
        int          exp_lat;
        logic [15:0] exp_dout;
        idx      = a[8:1];
        exp_hit  = rd && m_vld[s] && (m_last[s] == idx);
        exp_lat  = (exp_hit || s == 1) ? 1 : LAT;
        exp_dout = rd ? m_mem[s][idx] : m_dout[s];
        sel      = (s == 1);
        cd       = 1'($urandom_range(0, 1));
        drive(s, rd, !rd, a, d);
        cyc       = 0;
        stall_cyc = 0;
        do begin
            @(posedge clk); #1;
            cyc++;
            if (o_stall) stall_cyc++;
            if (!o_done) begin
                // Address/data wander while the op is held; must be ignored
                drive(s, rd, !rd, 16'($urandom) & 16'hFFFE, 16'($urandom));
            end
        end while (!o_done && cyc < 40);
        check("done_latency", 32'(cyc), 32'(exp_lat));
        check("stall_cycles", 32'(stall_cyc), 32'(exp_lat));
        check("cache_hit", 32'(o_hit), 32'(exp_hit));
        check("data_out", 32'(o_dout), 32'(exp_dout));
        if (!rd) m_mem[s][idx] = d;
        m_last[s] = idx;
        m_vld[s]  = 1'b1;
        m_dout[s] = exp_dout;
        drive(s, 1'b0, 1'b0, a, d);
        @(posedge clk); #1;
        check("idle_after_done", 32'({o_done, o_stall}), 32'h0);
    endtask

    initial begin
        rst = 1'b1;
        cd  = 1'b0;
        drive(0, 1'b0, 1'b0, 16'h0, 16'h0);
        drive(1, 1'b0, 1'b0, 16'h0, 16'h0);
        model_reset();

        // Reset state
        #3;
        check("rst_flags0", 32'({done0, stall0, hit0, err0}), 32'h0);
        check("rst_dout0", 32'(dout0), 32'h0);
        check("rst_flags1", 32'({done1, stall1, hit1, err1}), 32'h0);
        check("rst_dout1", 32'(dout1), 32'h0);
        @(posedge clk); #1;
        rst = 1'b0;

        // Write then hit-read of the same word
        access(0, 1'b0, 16'h0010, 16'hBEEF);
        access(0, 1'b1, 16'h0010, 16'h0000);
        // Writes leave DataOut alone; read of another word takes the slow path
        access(0, 1'b0, 16'h0020, 16'h5A5A);
        access(0, 1'b0, 16'h0010, 16'h1111);
        access(0, 1'b1, 16'h0020, 16'h0000);
        // Write to the last index keeps the fast path coherent
        access(0, 1'b0, 16'h0010, 16'h2222);
        access(0, 1'b1, 16'h0010, 16'h0000);

        // Rd and Wr together: sticky error, later valid requests ignored
        drive(0, 1'b1, 1'b1, 16'h0004, 16'h0000);
        @(posedge clk); #1;
        check("both_err", 32'(err0), 32'h1);
        check("both_idle", 32'({done0, stall0}), 32'h0);
        drive(0, 1'b1, 1'b0, 16'h0010, 16'h0000);
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            check("err_ignores_req", 32'({done0, stall0, err0}), 32'h1);
        end
        drive(0, 1'b0, 1'b0, 16'h0, 16'h0);
        rst = 1'b1;
        #1;
        check("rst_clears_err", 32'(err0), 32'h0);
        @(posedge clk); #1;
        rst = 1'b0;
        model_reset();

        // Misaligned read
        drive(0, 1'b1, 1'b0, 16'h0003, 16'h0000);
        @(posedge clk); #1;
        check("odd_err", 32'(err0), 32'h1);
        check("odd_no_stall", 32'({done0, stall0}), 32'h0);
        drive(0, 1'b0, 1'b0, 16'h0, 16'h0);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        model_reset();

        // Reset aborts a pending write
        access(0, 1'b0, 16'h0030, 16'hCAFE);
        drive(0, 1'b0, 1'b1, 16'h0030, 16'h1234);
        @(posedge clk); #1;
        check("abort_busy", 32'({done0, stall0}), 32'h1);
        @(posedge clk); #1;
        check("abort_no_done", 32'(done0), 32'h0);
        rst = 1'b1;
        #1;
        check("abort_async", 32'({done0, stall0}), 32'h0);
        drive(0, 1'b0, 1'b0, 16'h0, 16'h0);
        @(posedge clk); #1;
        rst = 1'b0;
        model_reset();
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            check("abort_stays_idle", 32'({done0, stall0}), 32'h0);
        end
        access(0, 1'b1, 16'h0030, 16'h0000);

        // LATENCY=1 instance: back-to-back reads, each one cycle
        access(1, 1'b0, 16'h0040, 16'hAAAA);
        access(1, 1'b0, 16'h0042, 16'h5555);
        access(1, 1'b1, 16'h0040, 16'h0000);
        access(1, 1'b1, 16'h0042, 16'h0000);
        access(1, 1'b1, 16'h0042, 16'h0000);

        // Randomized traffic over a small window so hits recur
        for (int s = 0; s < 2; s++) begin
            for (int i = 0; i < 8; i++) begin
                access(s, 1'b0, 16'h00A0 + 16'(2 * i), 16'($urandom));
            end
            for (int k = 0; k < 25; k++) begin
                w = int'($urandom_range(0, 7));
                access(s, ($urandom_range(0, 2) != 0), 16'h00A0 + 16'(2 * w), 16'($urandom));
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
